alu_op_sequencer: RTL and testbench

- Shares the single integer datapath (int_calc, int_bit_manip, int_log) between two command requesters, e.g. the button/switch console FSM and a UART command path.
- Round-robin arbitrates between requesters, reads operands from a 4-entry 16-bit register file, and drives the shared unit operation and operand buses.
- Waits the fixed unit latency, selects the result, writes it back to the register file, and returns a response to the winning requester.
- Sits between the top-level control FSM and the integer units; it replaces ad-hoc opa/opb/op2 registers.

---
 rtl/alu_op_sequencer_pkg.sv | 19 +
 rtl/alu_op_sequencer_if.sv | 20 ++
 rtl/alu_op_sequencer_rr_arb2.sv | 18 +
 rtl/alu_op_sequencer.sv | 112 +++++++++++
 tb/tb_alu_op_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: command layout, unit/op codes and FSM states shared by the sequencer
package alu_op_sequencer_pkg;
   typedef enum logic [1:0] {UNIT_CALC, UNIT_MANIP, UNIT_LOGIC, UNIT_MOVE} unit_e;
   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_REM = 3'b100;
   typedef struct packed {
      unit_e      unit;
      logic [2:0] op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] dst;
      logic       use_imm;
      logic [1:0] rsvd;
   } cmd_t;
   function automatic logic div_like(input logic [2:0] op);
      return op == OP_DIV || op == OP_REM;
   endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: requester handshake and shared integer-unit buses
interface alu_op_sequencer_if #(parameter int DATA_W = 16, parameter int CMD_W = 14);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*CMD_W-1:0]  req_cmd;
   logic [2*DATA_W-1:0] req_imm;
   logic [1:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_data;
   logic                rsp_err;
   logic [2:0]          unit_op;
   logic [DATA_W-1:0]   unit_opa;
   logic [DATA_W-1:0]   unit_opb;
   logic [DATA_W-1:0]   calc_out;
   logic [DATA_W-1:0]   manip_out;
   logic [DATA_W-1:0]   logic_out;
   modport master (output req_valid, req_cmd, req_imm, calc_out, manip_out, logic_out,
                   input req_ready, rsp_valid, rsp_data, rsp_err, unit_op, unit_opa, unit_opb);
   modport slave (input req_valid, req_cmd, req_imm, calc_out, manip_out, logic_out,
                  output req_ready, rsp_valid, rsp_data, rsp_err, unit_op, unit_opa, unit_opb);
endinterface

// File: rtl/alu_op_sequencer_rr_arb2.sv
// rr_arb2: two-requester round-robin grant, pointer advanced when a transaction completes
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       en_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);
   logic ptr_q;
   // pointer favours the requester that was not just served
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= 1'b0;
      else if (en_i) ptr_q <= ~last_i;
   end
   // a lone requester wins outright; contention is settled by the pointer
   always_comb gnt_o = &req_i ? (ptr_q ? 2'b10 : 2'b01) : req_i;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: arbitrates two command sources onto the shared integer units with a 4-entry register file
module alu_op_sequencer import alu_op_sequencer_pkg::*; #(
   parameter int DATA_W   = 16,
   parameter int UNIT_LAT = 1,
   parameter int CMD_W    = 14
) (
   input  logic                clk,
   input  logic                rst,
   alu_op_sequencer_if.slave   bus,
   output logic                busy,
   input  logic [1:0]          dbg_sel,
   output logic [DATA_W-1:0]   dbg_data
);
   localparam int CNT_W = $clog2(UNIT_LAT + 1);
   state_e              state_q, state_d;
   cmd_t                cmd_q;
   logic [DATA_W-1:0]   imm_q, opa_q, opb_q, rsp_data_q, res;
   logic [DATA_W-1:0]   rf_q [4];
   logic [2:0]          op_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [1:0]          gnt;
   logic                g_q, rsp_err_q, err, accept;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_i  (bus.req_valid),
      .en_i   (state_q == S_WB),
      .last_i (g_q),
      .gnt_o  (gnt)
   );

   assign accept       = state_q == S_IDLE && |gnt;
   assign bus.unit_op  = op_q;
   assign bus.unit_opa = opa_q;
   assign bus.unit_opb = opb_q;
   assign dbg_data     = rf_q[dbg_sel];

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else state_q <= state_d;
   end

   // next state: moves skip the unit wait, EXEC leaves when the latency counter expires
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = accept ? S_READ : S_IDLE;
         S_READ:  state_d = cmd_q.unit == UNIT_MOVE ? S_WB : S_EXEC;
         S_EXEC:  state_d = cnt_q == '0 ? S_WB : S_EXEC;
         default: state_d = S_IDLE;
      endcase
   end

   // result select, error detection and handshake/response outputs
   always_comb begin
      res = '0;
      err = 1'b0;
      case (cmd_q.unit)
         UNIT_CALC: begin
            err = div_like(cmd_q.op) && opb_q == '0;
            res = err ? '0 : bus.calc_out;
         end
         UNIT_MANIP: res = bus.manip_out;
         UNIT_LOGIC: res = bus.logic_out;
         default: begin
            err = cmd_q.op > 3'd1;
            res = cmd_q.op == 3'd0 ? imm_q : (cmd_q.op == 3'd1 ? rf_q[cmd_q.src_a] : '0);
         end
      endcase
      busy          = state_q != S_IDLE;
      bus.req_ready = state_q == S_IDLE ? gnt : 2'b00;
      bus.rsp_valid = state_q == S_WB ? {g_q, ~g_q} : 2'b00;
      bus.rsp_data  = state_q == S_WB ? res : rsp_data_q;
      bus.rsp_err   = state_q == S_WB ? err : rsp_err_q;
   end

   // datapath: capture on accept, load unit buses in READ, count latency, write back in WB
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g_q        <= 1'b0;
         cmd_q      <= '0;
         imm_q      <= '0;
         op_q       <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      end else begin
         if (accept) begin
            g_q   <= gnt[1];
            cmd_q <= cmd_t'(gnt[1] ? bus.req_cmd[2*CMD_W-1:CMD_W] : bus.req_cmd[CMD_W-1:0]);
            imm_q <= gnt[1] ? bus.req_imm[2*DATA_W-1:DATA_W] : bus.req_imm[DATA_W-1:0];
         end
         if (state_q == S_READ) begin
            op_q  <= cmd_q.op;
            opa_q <= rf_q[cmd_q.src_a];
            opb_q <= cmd_q.use_imm ? imm_q : rf_q[cmd_q.src_b];
            cnt_q <= CNT_W'(UNIT_LAT - 1);
         end
         if (state_q == S_EXEC && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
         if (state_q == S_WB) begin
            rsp_data_q <= res;
            rsp_err_q  <= err;
            if (!err) rf_q[cmd_q.dst] <= res;
         end
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed stimulus with a response scoreboard and simple clocked unit models
module tb_alu_op_sequencer;
   localparam int LAT = 1;
   typedef struct {
      int          r;
      logic [15:0] data;
      logic        err;
      logic        dk;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk, rst, busy;
   logic [1:0]  dbg_sel;
   logic [15:0] dbg_data;
   int          checks = 0, errors = 0, cyc = 0;
   int          rsp_cnt [2];
   int          gnt_log [$];
   exp_t        q [$];
   logic [15:0] sh [4];

   alu_op_sequencer_if #(.DATA_W(16), .CMD_W(14)) bus ();

   alu_op_sequencer #(.DATA_W(16), .UNIT_LAT(LAT), .CMD_W(14)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] calc_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a * b;
         3'd3: return b == 0 ? 16'h0 : a / b;
         3'd4: return b == 0 ? 16'h0 : a % b;
         default: return 16'h0;
      endcase
   endfunction

   function automatic logic [15:0] manip_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0: return a << b[3:0];
         3'd1: return a >> b[3:0];
         3'd2: return ~a;
         default: return a;
      endcase
   endfunction

   function automatic logic [15:0] logic_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         default: return 16'h0;
      endcase
   endfunction

   function automatic logic [13:0] mk(input int u, input int op, input int sa, input int sb, input int d, input int ui);
      return {u[1:0], op[2:0], sa[1:0], sb[1:0], d[1:0], ui[0], 2'b00};
   endfunction

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      bus.calc_out  <= calc_f(bus.unit_op, bus.unit_opa, bus.unit_opb);
      bus.manip_out <= manip_f(bus.unit_op, bus.unit_opa, bus.unit_opb);
      bus.logic_out <= logic_f(bus.unit_op, bus.unit_opa, bus.unit_opb);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // accept monitor: predicts each accepted command against the shadow register file
   always @(negedge clk) begin
      exp_t e;
      logic [13:0] c;
      logic [15:0] imm, a, b;
      #4;
      if (rst) for (int r = 0; r < 2; r++) if (bus.req_valid[r] && bus.req_ready[r]) begin
         c   = bus.req_cmd[r*14 +: 14];
         imm = bus.req_imm[r*16 +: 16];
         a   = sh[c[8:7]];
         b   = c[2] ? imm : sh[c[6:5]];
         e.r = r; e.err = 0; e.dk = 1; e.acc = cyc;
         e.lat = c[13:12] == 2'd3 ? 2 : 2 + LAT;
         case (c[13:12])
            2'd0: begin
               e.err  = (c[11:9] == 3'd3 || c[11:9] == 3'd4) && b == 0;
               e.data = e.err ? 16'h0 : calc_f(c[11:9], a, b);
            end
            2'd1: e.data = manip_f(c[11:9], a, b);
            2'd2: e.data = logic_f(c[11:9], a, b);
            default: begin
               e.data = c[11:9] == 3'd0 ? imm : (c[11:9] == 3'd1 ? a : 16'h0);
               e.err  = c[11:9] > 3'd1;
               e.dk   = !e.err;
            end
         endcase
         if (!e.err) sh[c[4:3]] = e.data;
         q.push_back(e);
         gnt_log.push_back(r);
      end
   end

   // response monitor: pops the scoreboard on every response pulse
   always @(negedge clk) begin
      exp_t e;
      if (rst && bus.rsp_valid != 2'b00) begin
         if (q.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
         else begin
            e = q.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), e.r == 1 ? 32'h2 : 32'h1);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            if (e.dk) chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            chk("rsp_latency", cyc - e.acc, e.lat);
            rsp_cnt[e.r]++;
         end
      end
   end

   task automatic issue(input int r, input logic [13:0] cmd, input logic [15:0] imm);
      int n = 0;
      @(negedge clk);
      bus.req_cmd[r*14 +: 14] = cmd;
      bus.req_imm[r*16 +: 16] = imm;
      bus.req_valid[r] = 1'b1;
      #1;
      chk("ready_now", 32'(bus.req_ready), r == 1 ? 32'h2 : 32'h1);
      while (!bus.req_ready[r] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      bus.req_valid[r] = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((q.size() != 0 || busy) && n < 40);
      chk("idle_reached", 32'(n < 40), 32'h1);
   endtask

   task automatic dbg(input int sel, input logic [15:0] exp);
      dbg_sel = sel[1:0];
      #1;
      chk($sformatf("dbg_reg%0d", sel), 32'(dbg_data), 32'(exp));
   endtask

   initial begin
      int n, base, b0, b1;
      rst = 0;
      dbg_sel = 0;
      bus.req_valid = 0;
      bus.req_cmd = '0;
      bus.req_imm = '0;
      rsp_cnt[0] = 0;
      rsp_cnt[1] = 0;
      for (int i = 0; i < 4; i++) sh[i] = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
      chk("rst_unit_opa", 32'(bus.unit_opa), 32'h0);
      dbg(0, 16'h0);
      rst = 1;
      // move immediate into reg1
      issue(0, mk(3, 0, 0, 0, 1, 0), 16'h0005);
      wait_idle();
      dbg(1, 16'h0005);
      // calc add reg1 + imm into reg2, unit buses held during EXEC
      issue(0, mk(0, 0, 1, 0, 2, 1), 16'h0003);
      @(negedge clk);
      chk("exec_unit_op", 32'(bus.unit_op), 32'h0);
      chk("exec_unit_opa", 32'(bus.unit_opa), 32'h5);
      chk("exec_unit_opb", 32'(bus.unit_opb), 32'h3);
      wait_idle();
      dbg(2, 16'h0008);
      chk("idle_bus_hold", 32'(bus.unit_opa), 32'h5);
      // divide by zero leaves reg3 untouched, then a good command clears the error
      issue(0, mk(3, 0, 0, 0, 3, 0), 16'hAAAA);
      wait_idle();
      issue(1, mk(0, 3, 0, 0, 3, 1), 16'h0000);
      wait_idle();
      chk("err_held", 32'(bus.rsp_err), 32'h1);
      dbg(3, 16'hAAAA);
      issue(0, mk(2, 1, 1, 2, 0, 0), 16'h0000);
      wait_idle();
      chk("err_cleared", 32'(bus.rsp_err), 32'h0);
      dbg(0, 16'h000D);
      issue(0, mk(1, 0, 1, 0, 2, 1), 16'h0002);
      wait_idle();
      dbg(2, 16'h0014);
      issue(1, mk(0, 4, 2, 0, 1, 1), 16'h0003);
      wait_idle();
      dbg(1, 16'h0002);
      // lone req1 re-granted; bad move op errors without writeback
      issue(1, mk(3, 1, 3, 0, 0, 0), 16'h0000);
      wait_idle();
      dbg(0, 16'hAAAA);
      issue(1, mk(3, 2, 0, 0, 1, 0), 16'h0009);
      wait_idle();
      chk("move_err", 32'(bus.rsp_err), 32'h1);
      dbg(1, 16'h0002);
      // reset during EXEC aborts the command
      issue(0, mk(0, 0, 1, 0, 3, 1), 16'h0001);
      @(negedge clk);
      chk("exec_busy", 32'(busy), 32'h1);
      rst = 0;
      #1;
      q.delete();
      for (int i = 0; i < 4; i++) sh[i] = 0;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      for (int i = 0; i < 4; i++) dbg(i, 16'h0);
      b0 = rsp_cnt[0];
      b1 = rsp_cnt[1];
      repeat (2) @(negedge clk);
      rst = 1;
      repeat (8) @(negedge clk);
      chk("abort_no_rsp", rsp_cnt[0] + rsp_cnt[1], b0 + b1);
      // both requesters valid continuously: grants alternate starting at req0
      @(negedge clk);
      bus.req_cmd = {mk(3, 0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0, 1)};
      bus.req_imm = {16'h0077, 16'h0001};
      bus.req_valid = 2'b11;
      base = gnt_log.size();
      n = 0;
      while (gnt_log.size() < base + 4 && n < 60) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid = 2'b00;
      chk("alt_accepts", 32'(n < 60), 32'h1);
      wait_idle();
      for (int i = 0; i < 4; i++)
         if (base + i < gnt_log.size()) chk($sformatf("alt_grant%0d", i), gnt_log[base + i], i % 2);
      chk("alt_rsp0", rsp_cnt[0] - b0, 2);
      chk("alt_rsp1", rsp_cnt[1] - b1, 2);
      dbg(0, 16'h0002);
      dbg(1, 16'h0077);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
